// File: rtl/usb_std_req_responder.sv
// EP0 IN data-stage responder for standard device-to-host control requests.
// Optional USB_STRING_DESC_EN adds GET_DESCRIPTOR(string) via a ROM start-address table.
module usb_std_req_responder #(
    parameter int MAX_PACKET_SIZE  = 64,
    parameter int ROM_ADDR_W       = 8,
    parameter int DEVICE_DESC_ADDR = 0,
    parameter int DEVICE_DESC_LEN  = 18,
    parameter int CONFIG_DESC_ADDR = 18,
    parameter int CONFIG_DESC_LEN  = 34,
    parameter int NUM_INTERFACES   = 1,
    parameter int NUM_ENDPOINTS    = 2
`ifdef USB_STRING_DESC_EN
    ,
    parameter int STRING_TABLE_ADDR = 52,
    parameter int NUM_STRINGS       = 4
`endif
) (
    input  logic                     clk48,
    input  logic                     rst_n,
    input  logic [63:0]              setupPacket,
    input  logic                     setupValid,
    input  logic [1:0]               deviceState,
    input  logic [7:0]               configValue,
    input  logic [7:0]               altSetting,
    input  logic                     selfPowered,
    input  logic                     remoteWakeupEn,
    input  logic [NUM_ENDPOINTS-1:0] epHalt,
    input  logic                     inToken,
    output logic [ROM_ADDR_W-1:0]    romAddr,
    input  logic [7:0]               romData,
    output logic [7:0]               txData,
    output logic                     txValid,
    input  logic                     txReady,
    output logic                     txLast,
    output logic                     txZlp,
    output logic                     handled,
    output logic                     stall,
    output logic                     done
);

    typedef struct packed {
        logic [7:0]  bm_request_type;
        logic [7:0]  b_request;
        logic [15:0] w_value;
        logic [15:0] w_index;
        logic [15:0] w_length;
    } setup_t;

    typedef enum logic [2:0] {
        IDLE, DECODE, WAIT_IN, FETCH, SEND, ZLP, STALL
    } state_t;

    localparam int PW = $clog2(MAX_PACKET_SIZE + 1);
    localparam logic [PW-1:0] MPS_P = PW'(MAX_PACKET_SIZE);
    localparam logic [15:0] MPS_R = 16'(MAX_PACKET_SIZE);

    localparam logic [7:0] GET_STATUS        = 8'd0;
    localparam logic [7:0] GET_DESCRIPTOR    = 8'd6;
    localparam logic [7:0] GET_CONFIGURATION = 8'd8;
    localparam logic [7:0] GET_INTERFACE     = 8'd10;

    state_t                state;
    setup_t                pkt;
    logic [15:0]           r;
    logic [PW-1:0]         p;
    logic                  full_q;
    logic                  z_q;
    logic                  zlp_owed;
    logic                  rom_src_q;
    logic [15:0]           resp_q;

    logic                  configured;
    logic [4:0]            recip;
    logic [3:0]            ep;
    logic                  ep_bad;
    logic                  if_bad;
    logic [7:0]            dtype;
    logic [7:0]            dindex;
    logic                  halt;
    logic                  ours;
    logic                  err;
    logic                  rom_src;
    logic [15:0]           nat_len;
    logic [15:0]           resp;
    logic [ROM_ADDR_W-1:0] base;
    logic [15:0]           r_init;
    logic                  z_init;

`ifdef USB_STRING_DESC_EN
    logic [2:0]            dstep;
    logic                  str_wait;
`endif

    assign configured = (deviceState == 2'd2);
    assign recip      = pkt.bm_request_type[4:0];
    assign ep         = pkt.w_index[3:0];
    assign ep_bad     = {1'b0, ep} >= 5'(NUM_ENDPOINTS);
    assign if_bad     = pkt.w_index >= 16'(NUM_INTERFACES);
    assign dtype      = pkt.w_value[15:8];
    assign dindex     = pkt.w_value[7:0];

    always_comb begin
        halt = 1'b0;
        for (int i = 0; i < NUM_ENDPOINTS; i++) begin
            if (ep == 4'(i)) halt = epHalt[i];
        end
    end

    always_comb begin
        ours    = 1'b0;
        err     = 1'b0;
        rom_src = 1'b0;
        nat_len = '0;
        resp    = '0;
        base    = '0;
`ifdef USB_STRING_DESC_EN
        str_wait = 1'b0;
`endif
        if (pkt.bm_request_type[7] && pkt.bm_request_type[6:5] == 2'b00) begin
            ours = 1'b1;
            case (pkt.b_request)
                GET_STATUS: begin
                    nat_len = 16'd2;
                    case (recip)
                        5'd0: resp = {8'h00, 6'b0, remoteWakeupEn, selfPowered};
                        5'd1: err = if_bad || (!configured && pkt.w_index != 16'd0);
                        5'd2: begin
                            err  = ep_bad || (!configured && ep != 4'd0);
                            resp = {8'h00, 7'b0, halt};
                        end
                        default: err = 1'b1;
                    endcase
                end
                GET_CONFIGURATION: begin
                    nat_len = 16'd1;
                    resp    = {8'h00, configValue};
                end
                GET_INTERFACE: begin
                    nat_len = 16'd1;
                    resp    = {8'h00, altSetting};
                    err     = !configured || if_bad;
                end
                GET_DESCRIPTOR: begin
                    rom_src = 1'b1;
                    case (dtype)
                        8'd1: begin
                            nat_len = 16'(DEVICE_DESC_LEN);
                            base    = ROM_ADDR_W'(DEVICE_DESC_ADDR);
                        end
                        8'd2: begin
                            err     = (dindex != 8'd0);
                            nat_len = 16'(CONFIG_DESC_LEN);
                            base    = ROM_ADDR_W'(CONFIG_DESC_ADDR);
                        end
`ifdef USB_STRING_DESC_EN
                        8'd3: begin
                            err      = (dindex >= 8'(NUM_STRINGS));
                            str_wait = !err && (dstep != 3'd4);
                            nat_len  = {8'h00, romData};
                            base     = romAddr;
                        end
`endif
                        default: err = 1'b1;
                    endcase
                end
                default: err = 1'b1;
            endcase
        end
    end

    assign r_init = (pkt.w_length < nat_len) ? pkt.w_length : nat_len;
    assign z_init = (r_init == pkt.w_length);
    assign txData = rom_src_q ? romData : resp_q[7:0];

    always_ff @(posedge clk48 or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            pkt       <= '0;
            r         <= '0;
            p         <= '0;
            full_q    <= 1'b0;
            z_q       <= 1'b0;
            zlp_owed  <= 1'b0;
            rom_src_q <= 1'b0;
            resp_q    <= '0;
            romAddr   <= '0;
            txValid   <= 1'b0;
            txLast    <= 1'b0;
            txZlp     <= 1'b0;
            handled   <= 1'b0;
            stall     <= 1'b0;
            done      <= 1'b0;
`ifdef USB_STRING_DESC_EN
            dstep     <= '0;
`endif
        end else begin
            handled <= 1'b0;
            done    <= 1'b0;
            txZlp   <= 1'b0;
            if (setupValid) begin
                // A new SETUP always wins over whatever transfer is in flight
                pkt     <= setupPacket;
                stall   <= 1'b0;
                txValid <= 1'b0;
                txLast  <= 1'b0;
                state   <= DECODE;
`ifdef USB_STRING_DESC_EN
                dstep   <= '0;
`endif
            end else begin
                case (state)
                    IDLE: ;
                    DECODE: begin
`ifdef USB_STRING_DESC_EN
                        if (str_wait) begin
                            dstep <= dstep + 3'd1;
                            if (dstep == 3'd0)
                                romAddr <= ROM_ADDR_W'(STRING_TABLE_ADDR) + ROM_ADDR_W'(dindex);
                            if (dstep == 3'd2)
                                romAddr <= ROM_ADDR_W'(romData);
                        end else
`endif
                        begin
                            if (!ours) begin
                                state <= IDLE;
                            end else if (err) begin
                                stall <= 1'b1;
                                state <= STALL;
                            end else begin
                                handled <= 1'b1;
                                if (pkt.w_length == 16'd0) begin
                                    state <= IDLE;
                                end else begin
                                    r         <= r_init;
                                    z_q       <= z_init;
                                    zlp_owed  <= (r_init == 16'd0);
                                    romAddr   <= base;
                                    resp_q    <= resp;
                                    rom_src_q <= rom_src;
                                    state     <= WAIT_IN;
                                end
                            end
                        end
                    end
                    WAIT_IN: begin
                        if (inToken) begin
                            if (r != 16'd0) begin
                                p      <= (r < MPS_R) ? r[PW-1:0] : MPS_P;
                                full_q <= !(r < MPS_R);
                                state  <= FETCH;
                            end else if (zlp_owed) begin
                                state <= ZLP;
                            end
                        end
                    end
                    FETCH: begin
                        txValid <= 1'b1;
                        txLast  <= (p == PW'(1));
                        state   <= SEND;
                    end
                    SEND: begin
                        if (txReady) begin
                            txValid <= 1'b0;
                            txLast  <= 1'b0;
                            p       <= p - PW'(1);
                            r       <= r - 16'd1;
                            romAddr <= romAddr + ROM_ADDR_W'(1);
                            resp_q  <= {8'h00, resp_q[15:8]};
                            if (p > PW'(1)) begin
                                state <= FETCH;
                            end else if (r == 16'd1) begin
                                // Data exhausted: a full final packet owes a ZLP unless wLength was met
                                if (!full_q || z_q) begin
                                    done  <= 1'b1;
                                    state <= IDLE;
                                end else begin
                                    zlp_owed <= 1'b1;
                                    state    <= WAIT_IN;
                                end
                            end else begin
                                state <= WAIT_IN;
                            end
                        end
                    end
                    ZLP: begin
                        txZlp    <= 1'b1;
                        done     <= 1'b1;
                        zlp_owed <= 1'b0;
                        state    <= IDLE;
                    end
                    STALL: ;
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule
